// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage for one- and two-halfword instructions
// Outputs are combinational from iData; immediate-carrying instructions take two fetch cycles.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMM_BIT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  input  logic [15:0] iData,
  output logic [31:0] iAddr,
  output logic [15:0] instruction,
  output logic [15:0] imm,
  output logic [31:0] pc,
  output logic [31:0] nextPC,
  output logic        valid,
  output logic        flush
);

  typedef enum logic {
    FETCH_OP  = 1'b0,
    FETCH_IMM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic [31:0] pc_inc;
  logic        is_long;

  assign pc_inc  = pc_q + 32'd1;
  assign is_long = iData[IMM_BIT];
  assign iAddr   = pc_q;

  always_comb begin
    instruction = 16'h0000;
    imm         = 16'h0000;
    pc          = 32'h0000_0000;
    nextPC      = 32'h0000_0000;
    valid       = 1'b0;
    flush       = 1'b0;
    if (rst || redirect) begin
      flush = 1'b1;
    end else begin
      case (state_q)
        FETCH_OP: begin
          // First halfword of a long instruction is held back, not presented.
          if (!is_long) begin
            instruction = iData;
            pc          = pc_q;
            nextPC      = pc_inc;
            valid       = 1'b1;
          end
        end
        FETCH_IMM: begin
          instruction = hold_instr_q;
          imm         = iData;
          pc          = hold_pc_q;
          nextPC      = pc_inc;
          valid       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (redirect) begin
      state_d      = FETCH_OP;
      pc_d         = redirectPC;
      hold_instr_d = 16'h0000;
      hold_pc_d    = 32'h0000_0000;
    end else if (!stall) begin
      pc_d = pc_inc;
      case (state_q)
        FETCH_OP: begin
          if (is_long) begin
            state_d      = FETCH_IMM;
            hold_instr_d = iData;
            hold_pc_d    = pc_q;
          end
        end
        FETCH_IMM: state_d = FETCH_OP;
        default:   state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH_OP;
      pc_q         <= RESET_PC;
      hold_instr_q <= 16'h0000;
      hold_pc_q    <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

endmodule
